// File: rtl/cart_rom_arbiter.sv
// Shares one single-port cartridge ROM between two GB readers (round-robin) and, when
// CART_DL_PORT_EN is defined, a download writer that takes absolute priority.
module cart_rom_arbiter #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_data,
    input  logic              req2_valid,
    input  logic [ADDR_W-1:0] req2_addr,
    output logic              req2_ack,
    output logic [DATA_W-1:0] req2_data,
`ifdef CART_DL_PORT_EN
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_busy,
`endif
    output logic              mem_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StWr} state_e;

    localparam logic [3:0] LatCnt = 4'(MEM_LAT);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt2_q, gnt2_d;
    // Last GB served: 1 = GB2, so GB1 wins the first tie after reset.
    logic              rr2_q, rr2_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              req1_ack_q, req1_ack_d;
    logic              req2_ack_q, req2_ack_d;
    logic [DATA_W-1:0] req1_data_q, req1_data_d;
    logic [DATA_W-1:0] req2_data_q, req2_data_d;
    logic              pick2;

`ifdef CART_DL_PORT_EN
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              dl_pend_q, dl_pend_d;
    logic [ADDR_W-1:0] dl_addr_q, dl_addr_d;
    logic [DATA_W-1:0] dl_data_q, dl_data_d;
    logic              pend_clr;
`endif

    assign pick2 = req2_valid && (!req1_valid || !rr2_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt2_d      = gnt2_q;
        rr2_d       = rr2_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        req1_ack_d  = 1'b0;
        req2_ack_d  = 1'b0;
        req1_data_d = req1_data_q;
        req2_data_d = req2_data_q;
`ifdef CART_DL_PORT_EN
        mem_we_d    = 1'b0;
        mem_din_d   = mem_din_q;
        pend_clr    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
`ifdef CART_DL_PORT_EN
                if (dl_pend_q) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = dl_addr_q;
                    mem_din_d  = dl_data_q;
                    state_d    = StWr;
                end else
`endif
                if (req1_valid || req2_valid) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pick2 ? req2_addr : req1_addr;
                    cnt_d      = LatCnt;
                    gnt2_d     = pick2;
                    state_d    = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (gnt2_q) begin
                        req2_ack_d  = 1'b1;
                        req2_data_d = mem_dout;
                    end else begin
                        req1_ack_d  = 1'b1;
                        req1_data_d = mem_dout;
                    end
                    rr2_d   = gnt2_q;
                    state_d = StDone;
                end
            end
            // Requester drops valid on ack; this cycle keeps the stale request from re-granting.
            StDone: state_d = StIdle;
`ifdef CART_DL_PORT_EN
            StWr: begin
                pend_clr = 1'b1;
                state_d  = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            gnt2_q      <= 1'b0;
            rr2_q       <= 1'b1;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            req1_ack_q  <= 1'b0;
            req2_ack_q  <= 1'b0;
            req1_data_q <= '0;
            req2_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt2_q      <= gnt2_d;
            rr2_q       <= rr2_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            req1_ack_q  <= req1_ack_d;
            req2_ack_q  <= req2_ack_d;
            req1_data_q <= req1_data_d;
            req2_data_q <= req2_data_d;
        end
    end

`ifdef CART_DL_PORT_EN
    // A strobe while a write is still pending is dropped, not queued.
    always_comb begin
        dl_pend_d = dl_pend_q;
        dl_addr_d = dl_addr_q;
        dl_data_d = dl_data_q;
        if (pend_clr) begin
            dl_pend_d = 1'b0;
        end
        if (dl_wr && !dl_pend_q) begin
            dl_pend_d = 1'b1;
            dl_addr_d = dl_addr;
            dl_data_d = dl_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_q  <= 1'b0;
            mem_din_q <= '0;
            dl_pend_q <= 1'b0;
            dl_addr_q <= '0;
            dl_data_q <= '0;
        end else begin
            mem_we_q  <= mem_we_d;
            mem_din_q <= mem_din_d;
            dl_pend_q <= dl_pend_d;
            dl_addr_q <= dl_addr_d;
            dl_data_q <= dl_data_d;
        end
    end

    assign mem_we  = mem_we_q;
    assign mem_din = mem_din_q;
    assign dl_busy = dl_pend_q;
`else
    assign mem_we  = 1'b0;
    assign mem_din = '0;
`endif

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign req1_ack  = req1_ack_q;
    assign req2_ack  = req2_ack_q;
    assign req1_data = req1_data_q;
    assign req2_data = req2_data_q;

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Self-checking bench for cart_rom_arbiter (MEM_LAT = 2); download tests run only when
// CART_DL_PORT_EN is defined.
module tb_cart_rom_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        req1_valid, req2_valid;
    logic [23:0] req1_addr, req2_addr;
    logic        req1_ack, req2_ack;
    logic [15:0] req1_data, req2_data;
    logic        mem_rd, mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = 16'h0;
`ifdef CART_DL_PORT_EN
    logic        dl_wr;
    logic [23:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_busy;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk_sys = ~clk_sys;

    cart_rom_arbiter #(.ADDR_W(24), .DATA_W(16), .MEM_LAT(2)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ack   (req1_ack),
        .req1_data  (req1_data),
        .req2_valid (req2_valid),
        .req2_addr  (req2_addr),
        .req2_ack   (req2_ack),
        .req2_data  (req2_data),
`ifdef CART_DL_PORT_EN
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_busy    (dl_busy),
`endif
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    function automatic logic [15:0] dfun(input logic [23:0] a);
        return (a == 24'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h3C3C);
    endfunction

    // Two-cycle read latency: one register stage after the mem_rd cycle.
    always @(posedge clk_sys) if (mem_rd) mem_dout <= dfun(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        v1, v2;
        logic [23:0] a1, a2;
        logic        exp2;
        logic [23:0] eaddr;
        logic [15:0] edata;
    } vec_t;

    vec_t vecs[9];

    task automatic do_read(input string nm, input logic v1, input logic v2,
                           input logic [23:0] a1, input logic [23:0] a2, input logic exp2,
                           input logic [23:0] eaddr, input logic [15:0] edata);
        int rd_c, ack_c, n_rd;
        logic got2, got_both;
        logic [23:0] raddr;
        logic [15:0] gdata;
        rd_c = -1; ack_c = -1; n_rd = 0; got2 = 0; got_both = 0; raddr = '0; gdata = '0;
        req1_addr = a1; req2_addr = a2; req1_valid = v1; req2_valid = v2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_sys); #1;
            if (mem_rd) begin n_rd++; rd_c = i; raddr = mem_addr; end
            if (req1_ack || req2_ack) begin
                ack_c = i; got2 = req2_ack; got_both = req1_ack && req2_ack;
                gdata = req2_ack ? req2_data : req1_data;
                break;
            end
        end
        req1_valid = 0; req2_valid = 0;
        check({nm, "_ack_seen"}, 32'(ack_c >= 0), 1);
        check({nm, "_port"}, {got_both, got2}, {1'b0, exp2});
        check({nm, "_data"}, gdata, edata);
        check({nm, "_rd_addr"}, raddr, eaddr);
        check({nm, "_n_rd"}, n_rd, 1);
        check({nm, "_latency"}, ack_c - rd_c, 2);
        @(posedge clk_sys); #1;
        check({nm, "_ack_pulse"}, {req1_ack, req2_ack}, 0);
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        @(posedge clk_sys); #1;
        reset_n = 1;
        @(posedge clk_sys); #1;
    endtask

    initial begin
        int ack_order[4];
        int n_ack, n_stray;
        logic [23:0] a1_cur, a2_cur;
        logic out1, out2, we_seen;
        int issued, acked;

        vecs[0] = '{"v0_gb1_only", 1, 0, 24'h000123, 24'h000000, 0, 24'h000123, 16'hBEEF};
        vecs[1] = '{"v1_gb2_only", 0, 1, 24'h000000, 24'h000456, 1, 24'h000456, 16'h386A};
        vecs[2] = '{"v2_tie_gb1",  1, 1, 24'h0000A0, 24'h0000B0, 0, 24'h0000A0, 16'h3C9C};
        vecs[3] = '{"v3_tie_gb2",  1, 1, 24'h0000A1, 24'h0000B1, 1, 24'h0000B1, 16'h3C8D};
        vecs[4] = '{"v4_tie_gb1",  1, 1, 24'h0000A2, 24'h0000B2, 0, 24'h0000A2, 16'h3C9E};
        vecs[5] = '{"v5_gb1_max",  1, 0, 24'hFFFFFF, 24'h000000, 0, 24'hFFFFFF, 16'hC3C3};
        vecs[6] = '{"v6_tie_gb2",  1, 1, 24'h0000A3, 24'h0000B3, 1, 24'h0000B3, 16'h3C8F};
        vecs[7] = '{"v7_gb2_msb",  0, 1, 24'h000000, 24'h800000, 1, 24'h800000, 16'h3C3C};
        vecs[8] = '{"v8_tie_gb1",  1, 1, 24'h0000A4, 24'h0000B4, 0, 24'h0000A4, 16'h3C98};

        reset_n = 0; req1_valid = 0; req2_valid = 0; req1_addr = '0; req2_addr = '0;
`ifdef CART_DL_PORT_EN
        dl_wr = 0; dl_addr = '0; dl_data = '0;
`endif
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_strobes", {mem_rd, mem_we, req1_ack, req2_ack}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_rd_data", {req1_data, req2_data}, 0);
`ifdef CART_DL_PORT_EN
        check("rst_dl_busy", dl_busy, 0);
`endif
        reset_n = 1;
        @(posedge clk_sys); #1;

        for (int v = 0; v < 9; v++)
            do_read(vecs[v].name, vecs[v].v1, vecs[v].v2, vecs[v].a1, vecs[v].a2,
                    vecs[v].exp2, vecs[v].eaddr, vecs[v].edata);

        // Reset during a GB2 read: no ack, outputs clear at once, rr back to GB2.
        req2_addr = 24'h000777; req2_valid = 1;
        n_ack = 0;
        for (int i = 0; i < 10 && !mem_rd; i++) begin @(posedge clk_sys); #1; end
        check("midrst_rd_seen", mem_rd, 1);
        reset_n = 0;
        #1;
        check("midrst_strobes", {mem_rd, mem_we, req1_ack, req2_ack}, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_data", {req1_data, req2_data, mem_din}, 0);
`ifdef CART_DL_PORT_EN
        check("midrst_dl_busy", dl_busy, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_sys); #1;
            if (req2_ack) n_ack++;
        end
        reset_n = 1;
        check("midrst_no_ack", n_ack, 0);
        do_read("midrst_tie", 1, 1, 24'h000AAA, 24'h000777, 0, 24'h000AAA, 16'h3696);

        // Continuous re-requests from both readers must alternate GB1, GB2, GB1, GB2.
        pulse_reset();
        a1_cur = 24'h000A00; a2_cur = 24'h000B00;
        req1_addr = a1_cur; req2_addr = a2_cur; req1_valid = 1; req2_valid = 1;
        n_ack = 0;
        for (int i = 0; i < 60 && n_ack < 4; i++) begin
            @(posedge clk_sys); #1;
            if (req1_ack) begin
                check("alt_data1", req1_data, dfun(a1_cur));
                ack_order[n_ack] = 1; n_ack++;
                a1_cur = a1_cur + 24'd1; req1_addr = a1_cur;
            end else if (req2_ack) begin
                check("alt_data2", req2_data, dfun(a2_cur));
                ack_order[n_ack] = 2; n_ack++;
                a2_cur = a2_cur + 24'd1; req2_addr = a2_cur;
            end
        end
        req1_valid = 0; req2_valid = 0;
        check("alt_n_ack", n_ack, 4);
        check("alt_order", {ack_order[0][3:0], ack_order[1][3:0], ack_order[2][3:0],
                            ack_order[3][3:0]}, 32'h1212);
        @(posedge clk_sys); #1;

`ifdef CART_DL_PORT_EN
        begin
            int ack1_c, we_c, rd2_c, ack2_c, n_we;
            logic [23:0] we_addr, rd2_addr;
            logic [15:0] we_din, ack2_data;
            logic busy_we, busy_after;
            ack1_c = -1; we_c = -1; rd2_c = -1; ack2_c = -1; n_we = 0;
            we_addr = '0; rd2_addr = '0; we_din = '0; ack2_data = '0;
            busy_we = 0; busy_after = 1;
            req1_addr = 24'h000200; req2_addr = 24'h000300; req1_valid = 1; req2_valid = 1;
            for (int i = 0; i < 10 && !mem_rd; i++) begin @(posedge clk_sys); #1; end
            check("dl_gb1_grant", mem_addr, 24'h000200);
            dl_wr = 1; dl_addr = 24'h000010; dl_data = 16'h55AA;
            @(posedge clk_sys); #1;
            check("dl_busy_set", dl_busy, 1);
            dl_addr = 24'h000020; dl_data = 16'h1234;
            @(posedge clk_sys); #1;
            dl_wr = 0;
            for (int i = 0; i < 30; i++) begin
                if (req1_ack && ack1_c < 0) begin ack1_c = i; req1_valid = 0; end
                if (mem_we) begin
                    n_we++; we_c = i; we_addr = mem_addr; we_din = mem_din; busy_we = dl_busy;
                end
                if (we_c >= 0 && i == we_c + 1) busy_after = dl_busy;
                if (mem_rd && rd2_c < 0) begin rd2_c = i; rd2_addr = mem_addr; end
                if (req2_ack && ack2_c < 0) begin ack2_c = i; ack2_data = req2_data; req2_valid = 0; end
                @(posedge clk_sys); #1;
            end
            check("dl_n_we", n_we, 1);
            check("dl_we_addr", we_addr, 24'h000010);
            check("dl_we_din", we_din, 16'h55AA);
            check("dl_busy_at_we", busy_we, 1);
            check("dl_busy_after_we", busy_after, 0);
            check("dl_ack1_before_we", 32'(ack1_c >= 0 && ack1_c < we_c), 1);
            check("dl_we_before_rd2", 32'(we_c >= 0 && we_c < rd2_c), 1);
            check("dl_rd2_addr", rd2_addr, 24'h000300);
            check("dl_ack2_data", {32'(ack2_c >= 0), ack2_data}, {32'd1, 16'h3F3C});

            // Write from idle: mem_we two cycles after the strobe edge, busy clears one later.
            dl_wr = 1; dl_addr = 24'h000ABC; dl_data = 16'hC0DE;
            @(posedge clk_sys); #1;
            dl_wr = 0;
            check("dlidle_c1", {mem_we, dl_busy}, 2'b01);
            @(posedge clk_sys); #1;
            check("dlidle_c2", {mem_we, dl_busy}, 2'b11);
            check("dlidle_c2_bus", {mem_addr, mem_din}, {24'h000ABC, 16'hC0DE});
            @(posedge clk_sys); #1;
            check("dlidle_c3", {mem_we, dl_busy, mem_rd}, 3'b000);
        end
`endif

        // Random traffic: each request gets exactly one ack with model data.
        out1 = 0; out2 = 0; we_seen = 0; issued = 0; acked = 0; n_stray = 0;
        a1_cur = '0; a2_cur = '0;
        for (int c = 0; c < 30000 && acked < 1000; c++) begin
            if (mem_we) we_seen = 1;
            if (req1_ack) begin
                if (!out1) n_stray++;
                else check("rnd_data1", req1_data, dfun(a1_cur));
                out1 = 0; req1_valid = 0; acked++;
            end
            if (req2_ack) begin
                if (!out2) n_stray++;
                else check("rnd_data2", req2_data, dfun(a2_cur));
                out2 = 0; req2_valid = 0; acked++;
            end
            if (!out1 && issued < 1000 && $urandom_range(0, 1) == 1) begin
                a1_cur = 24'($urandom); req1_addr = a1_cur; req1_valid = 1; out1 = 1; issued++;
            end
            if (!out2 && issued < 1000 && $urandom_range(0, 1) == 1) begin
                a2_cur = 24'($urandom); req2_addr = a2_cur; req2_valid = 1; out2 = 1; issued++;
            end
            @(posedge clk_sys); #1;
        end
        req1_valid = 0; req2_valid = 0;
        check("rnd_acked", acked, 1000);
        check("rnd_stray_acks", n_stray, 0);
        check("rnd_no_we", we_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
